pueo_cmdproc_regwr: RTL
=======================

# pueo_cmdproc_regwr

Mode1 command packet parser sitting directly downstream of the command decoder's `cmdproc_*` byte stream. It assembles 5-byte packets (1 address byte, 4 data bytes MSB-first, `tlast` on byte 5) into single register-write transactions toward the sysclk register bank. It flags malformed packets and counts packets and errors. The upstream stream has no backpressure, so this block absorbs it with a one-deep holding register.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of the saturating packet and error counters.

Ports:
- `sysclk_i`  in  1  sole clock. Upstream bytes arrive at most once per 8 cycles.
- `sysclk_rstn_i`  in  1  reset. Synchronous, active-low.
- `cmdproc_rst_i`  in  1  single-cycle mode1 reset. Aborts the partial packet.
- `cmdproc_tdata`  in  8  byte.
- `cmdproc_tvalid`  in  1  single-cycle byte strobe. No tready exists; every strobe is consumed.
- `cmdproc_tlast`  in  1  end of packet. Qualified by tvalid.
- `wr_addr_o`  out  8  register address.
- `wr_data_o`  out  32  register data.
- `wr_valid_o`  out  1  write pending.
- `wr_ready_i`  in  1  bank accepts when `wr_valid_o && wr_ready_i`.
- `err_o`  out  3  one-cycle error pulses: {ovf, long, short}.
- `pkt_count_o`  out  CNT_WIDTH  completed packets that loaded the holding register. Saturating.
- `err_count_o`  out  CNT_WIDTH  total error events. Saturating.

## Operation
Parser FSM:
- **IDLE** (expects the address byte).
  - tvalid with tlast: short error; stay in IDLE.
  - tvalid without tlast: latch address, clear byte index, go to **DATA**.
- **DATA** (index 0..3). Each tvalid shifts the byte into the data shift register, MSB first.
  - Index < 3 with tlast: short error, go to IDLE.
  - Index < 3 without tlast: increment index.
  - Index == 3 with tlast: packet complete, go to IDLE.
  - Index == 3 without tlast: long error, go to **DISCARD**.
- **DISCARD**: ignore bytes until a tvalid with tlast, then go to IDLE. Only one long error is signalled per packet.

Completion handling:
- If the holding register is empty, or is draining this cycle (`wr_valid_o && wr_ready_i`), load address/data, set `wr_valid_o`, and increment `pkt_count_o`.
- Otherwise, drop the new packet and pulse ovf. The held write is preserved unchanged.

Other rules:
- `wr_valid_o` clears on handshake unless a simultaneous load occurs. `wr_addr_o`/`wr_data_o` are stable while `wr_valid_o` is high.
- `cmdproc_rst_i` forces IDLE and clears the index. No error is signalled. The holding register and counters are unaffected.
- If `cmdproc_rst_i` and tvalid occur in the same cycle, reset wins and the byte is discarded.
- `err_count_o` adds the number of bits set in `err_o`, saturating at all-ones. Only one error bit can be set per cycle, because short/long and ovf are mutually exclusive by construction.

## Timing
- Reset (`sysclk_rstn_i` low on a rising edge):
  - FSM goes to IDLE, index to 0.
  - `wr_valid_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `err_o`=0, both counters 0.
- Latency:
  - `wr_valid_o` rises on the cycle after the sysclk edge that samples byte 5.
  - `err_o` pulses on the cycle after the offending byte. Counters update in that same cycle.
- Handshake: standard valid/ready. Ready may be held low indefinitely. Pending data never changes until accepted.
- Counter saturation: at max, further events are still pulsed on `err_o` but do not wrap the counter.

## Structure
- Shared package `pueo_cmdproc_pkg`:
  - FSM state enum `cmdproc_state_t` {IDLE, DATA, DISCARD}.
  - `CMDPROC_PKT_BYTES = 5`.
  - Error bit indices `ERR_SHORT = 0`, `ERR_LONG = 1`, `ERR_OVF = 2`.
- One sub-module: `pueo_sat_counter` (parameter WIDTH; inputs inc amount, sync active-low reset; saturating). Instantiated twice.
- The parser and the holding register live in the top module.

## Test plan
- Bytes 0x12, 0xDE, 0xAD, 0xBE, 0xEF (tlast on last), 8 cycles apart, `wr_ready_i`=1 → one cycle of `wr_valid_o` with addr 0x12, data 0xDEADBEEF; `pkt_count_o`=1; `err_o` stays 0.
- 3 bytes with tlast on the 3rd → `err_o`=3'b001 one cycle after; `err_count_o`=1; no write. A following good packet completes normally.
- 7 bytes with tlast on the 7th → long pulse (3'b010) after byte 5 only; bytes 6–7 discarded; no write; next packet parses from IDLE.
- `wr_ready_i`=0, two good packets (addr 0x01, then 0x02) → 0x01 held; second packet produces ovf (3'b100). Then raise ready → 0x01 accepted; `pkt_count_o`=1. Separately, raising ready in the exact completion cycle of packet 2 → both accepted, no ovf.
- `cmdproc_rst_i` after 2 bytes, then a full packet → no error, write reflects only the post-reset packet. `cmdproc_rst_i` coincident with tvalid → byte dropped.
- Force `err_count_o` near max (CNT_WIDTH=4 build): 17 short packets → counter holds 15, all 17 pulses appear. Mid-packet `sysclk_rstn_i` low → all outputs 0 next cycle.

Source files
------------

// File: rtl/pueo_cmdproc_pkg.sv
// Shared types and constants for the mode1 command packet parser.
package pueo_cmdproc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    DISCARD = 2'd2
  } cmdproc_state_t;

  localparam int CMDPROC_PKT_BYTES = 5;

  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_OVF   = 2;

endpackage

// File: rtl/pueo_sat_counter.sv
// Event counter that adds a small increment each cycle and sticks at all-ones.
module pueo_sat_counter #(
  parameter int WIDTH     = 16,
  parameter int INC_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     count
);

  logic [WIDTH:0] sum;

  // One extra bit catches overflow; the increment is far smaller than the range.
  assign sum = {1'b0, count} + {{(WIDTH + 1 - INC_WIDTH){1'b0}}, inc};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (sum[WIDTH]) begin
      count <= '1;
    end else begin
      count <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pueo_cmdproc_regwr.sv
// Assembles 5-byte mode1 packets into register writes behind a one-deep
// holding register; flags short/long/overflow packets and counts them.
module pueo_cmdproc_regwr
  import pueo_cmdproc_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 sysclk_i,
  input  logic                 sysclk_rstn_i,
  input  logic                 cmdproc_rst_i,
  input  logic [7:0]           cmdproc_tdata,
  input  logic                 cmdproc_tvalid,
  input  logic                 cmdproc_tlast,
  output logic [7:0]           wr_addr_o,
  output logic [31:0]          wr_data_o,
  output logic                 wr_valid_o,
  input  logic                 wr_ready_i,
  output logic [2:0]           err_o,
  output logic [CNT_WIDTH-1:0] pkt_count_o,
  output logic [CNT_WIDTH-1:0] err_count_o,
  output cmdproc_state_t       dbg_state_o
);

  // Write handshake: a write transfers on any sysclk edge where wr_valid_o and
  // wr_ready_i are both high; until then wr_addr_o/wr_data_o never change.

  cmdproc_state_t state_q;
  logic [1:0]     idx_q;
  logic [7:0]     addr_q;
  logic [23:0]    data_sr;

  logic byte_ok, in_data, last_idx;
  logic pkt_done, short_err, long_err, drain, load;
  logic [2:0] err_next;
  logic [1:0] err_inc;

  assign byte_ok   = cmdproc_tvalid && !cmdproc_rst_i;
  assign in_data   = (state_q == DATA);
  assign last_idx  = (idx_q == 2'd3);
  assign pkt_done  = byte_ok && in_data && last_idx && cmdproc_tlast;
  assign short_err = byte_ok && cmdproc_tlast && ((state_q == IDLE) || (in_data && !last_idx));
  assign long_err  = byte_ok && in_data && last_idx && !cmdproc_tlast;
  assign drain     = wr_valid_o && wr_ready_i;
  assign load      = pkt_done && (!wr_valid_o || drain);

  always_comb begin
    err_next            = 3'b000;
    err_next[ERR_SHORT] = short_err;
    err_next[ERR_LONG]  = long_err;
    err_next[ERR_OVF]   = pkt_done && !load;
  end

  assign err_inc     = {1'b0, err_next[0]} + {1'b0, err_next[1]} + {1'b0, err_next[2]};
  assign dbg_state_o = state_q;

  always_ff @(posedge sysclk_i) begin
    if (!sysclk_rstn_i) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      addr_q     <= 8'h00;
      data_sr    <= 24'h0;
      err_o      <= 3'b000;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= 8'h00;
      wr_data_o  <= 32'h0;
    end else begin
      err_o <= err_next;

      if (load) begin
        wr_valid_o <= 1'b1;
        wr_addr_o  <= addr_q;
        wr_data_o  <= {data_sr, cmdproc_tdata};
      end else if (drain) begin
        wr_valid_o <= 1'b0;
      end

      // A mode1 reset outranks any byte arriving in the same cycle.
      if (cmdproc_rst_i) begin
        state_q <= IDLE;
        idx_q   <= 2'd0;
      end else if (cmdproc_tvalid) begin
        case (state_q)
          IDLE: begin
            if (!cmdproc_tlast) begin
              addr_q  <= cmdproc_tdata;
              idx_q   <= 2'd0;
              state_q <= DATA;
            end
          end
          DATA: begin
            data_sr <= {data_sr[15:0], cmdproc_tdata};
            if (cmdproc_tlast) begin
              state_q <= IDLE;
            end else if (last_idx) begin
              state_q <= DISCARD;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
          DISCARD: begin
            if (cmdproc_tlast) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  pueo_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(2)) u_pkt_cnt (
    .clk   (sysclk_i),
    .rstn  (sysclk_rstn_i),
    .inc   ({1'b0, load}),
    .count (pkt_count_o)
  );

  pueo_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(2)) u_err_cnt (
    .clk   (sysclk_i),
    .rstn  (sysclk_rstn_i),
    .inc   (err_inc),
    .count (err_count_o)
  );

endmodule
